// File: rtl/bcd_display_scan_if.sv
// Digit-capture inputs and multiplexed 7-segment outputs of the BCD display scanner.
interface bcd_display_scan_if;
    logic [3:0] decenas;
    logic [3:0] unidades;
    logic       load;
    logic       blank_lz;
    logic [6:0] seg;
    logic [3:0] an;
    logic       digit_err;

    modport master (
        output decenas, unidades, load, blank_lz,
        input  seg, an, digit_err
    );

    modport slave (
        input  decenas, unidades, load, blank_lz,
        output seg, an, digit_err
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Purpose: latch two BCD digits and scan them onto a common-anode 7-segment display.
// Latency: 1 clk from capture or digit-slot change to seg/an/digit_err.
// Backpressure: none; load is a one-cycle strobe that is always accepted.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_display_scan_if.slave     bus
);

    typedef enum logic {S_UNITS = 1'b0, S_TENS = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               tick;
    logic [3:0]         dec_r, uni_r;
    logic [6:0]         seg_d, seg_q;
    logic [3:0]         an_d, an_q;
    logic               err_d, err_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_r <= 4'd0;
            uni_r <= 4'd0;
        end else if (bus.load) begin
            dec_r <= bus.decenas;
            uni_r <= bus.unidades;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_UNITS;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from the current slot and digits, then registered.
    always_comb begin
        state_d = state_q;
        an_d    = 4'b1110;
        seg_d   = seg_decode(uni_r);
        err_d   = (dec_r > 4'd9) || (uni_r > 4'd9);
        case (state_q)
            S_UNITS: begin
                if (tick) state_d = S_TENS;
            end
            S_TENS: begin
                if (tick) state_d = S_UNITS;
                if (bus.blank_lz && dec_r == 4'd0) begin
                    an_d  = 4'b1111;
                    seg_d = 7'h7F;
                end else begin
                    an_d  = 4'b1101;
                    seg_d = seg_decode(dec_r);
                end
            end
            default: state_d = S_UNITS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
            err_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            err_q <= err_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.digit_err = err_q;

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the 5-bit binary-to-BCD converter.
- Captures the tens and units digits on a load strobe.
- Time-multiplexes the two digits onto a common-anode 7-segment display: active-low segments, active-low digit enables.
- Provides a refresh divider, a digit-select state machine, leading-zero blanking and invalid-BCD flagging.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (must be ≥ 2).
- CNT_W, 16, width of the refresh counter (must satisfy 2^CNT_W ≥ REFRESH_DIV).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- decenas  input  4  BCD tens digit from the converter.
- unidades  input  4  BCD units digit from the converter.
- load  input  1  capture strobe, 1 cycle, samples decenas/unidades.
- blank_lz  input  1  1 = blank the tens digit when the captured tens digit is 0.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit enables, active-low; an[0] = units, an[1] = tens, an[3:2] are always 1.
- digit_err  output  1  registered; 1 while either captured digit is > 9.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - Digit registers cleared to 0, refresh counter cleared to 0, state = S_UNITS.
  - seg = 7'h7F, an = 4'hF, digit_err = 0.
  - Outputs hold these values until the first rising clk edge after rst_n deasserts, including when reset is asserted mid-scan.
- Capture: on a clk edge with load = 1, dec_r <= decenas and uni_r <= unidades. Without load, the registers hold.
- Refresh counter:
  - Increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and asserts tick for that cycle.
- State machine, two states:
  - S_UNITS -> S_TENS on tick.
  - S_TENS -> S_UNITS on tick.
  - No other transitions.
- Output register: seg, an and digit_err are registered from the current state and the current dec_r/uni_r.
  - Latency from a state change or capture to the outputs is 1 clk.
  - A load and a tick on the same edge are both applied; the following output update uses the new digit and the new state.
- Digit enables:
  - S_UNITS: an = 4'b1110.
  - S_TENS: an = 4'b1101.
  - Exception: in S_TENS with blank_lz = 1 and dec_r = 0, an = 4'b1111 and seg = 7'h7F.
- Segment decode (active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19.
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - Any value 10–15 = 3F (dash, g only).
- digit_err = (dec_r > 9) | (uni_r > 9). It is independent of the scan state.
- Digit dwell: each digit is lit for exactly REFRESH_DIV cycles. The full scan period is 2·REFRESH_DIV cycles.
- blank_lz is combinational into the output register and takes effect on the next edge.
- Size is 2 registered digits plus a counter; 120–200 lines of RTL are expected.

Test Plan (REFRESH_DIV = 4):
1. Reset, then release with no load.
   - Expect seg = 7F and an = F during reset.
   - 1 clk after release: an = E, seg = 40.
   - After 4 cycles: an = D, seg = 40.
2. load with decenas = 3, unidades = 1.
   - Expect units slot seg = 79 (an = E) and tens slot seg = 30 (an = D).
   - Each slot lasts exactly 4 cycles.
   - digit_err = 0.
3. Load decenas = 0, unidades = 7 with blank_lz = 1.
   - Expect tens slot an = F, seg = 7F; units slot seg = 78.
   - Drop blank_lz to 0: the tens slot shows seg = 40 after 1 clk.
4. Load decenas = 0xC, unidades = 5.
   - Expect tens seg = 3F, units seg = 12.
   - digit_err = 1 from 1 clk after load until a valid load (e.g. 2/9 gives 24/10), after which digit_err = 0.
5. Assert load on the same edge as tick, with new digits 1/8.
   - The next output shows the new state with the new digit (e.g. tens seg = 79).
   - No stale-digit cycle.
6. Assert rst_n = 0 mid-scan in S_TENS.
   - Outputs go to 7F/F immediately without waiting for clk.
   - After release: units slot first, counter restarts at 0, digits read 0.
